msrv32_store_unit: RTL and testbench
====================================

MSRV32_STORE_UNIT -- requirements
Module: msrv32_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: consecutive not-ready cycles that abort a bus transfer (range 1..255).
REQ-002 SHALL have ports:
  ms_riscv32_mp_clk_in  in  1  clock; all state updates on its rising edge
  ms_riscv32_mp_rst_in  in  1  reset, synchronous, active-low
  store_req_in  in  1  store request from decode; sampled only in IDLE
  iadder_in  in  32  effective byte address
  rs2_in  in  32  store source data
  store_size_in  in  2  00 byte, 01 half, 10 word, 11 illegal
  ahb_ready_in  in  1  bus ready (HREADY)
  ahb_resp_in  in  1  bus response; 1 = error, valid only when ahb_ready_in=1
  ms_riscv32_mp_dmaddr_out  out  32  word-aligned address {addr[31:2],2'b00}
  ms_riscv32_mp_dmdata_out  out  32  lane-replicated write data
  ms_riscv32_mp_dmwr_mask_out  out  4  byte-lane write strobes
  ms_riscv32_mp_dmwr_req_out  out  1  write request, high in ADDR only
  ahb_htrans_out  out  2  2'b10 NONSEQ in ADDR, else 2'b00 IDLE
  su_busy_out  out  1  stall to pipeline, high in ADDR and DATA
  store_done_out  out  1  one-cycle pulse, successful completion
  store_err_out  out  1  one-cycle pulse, bus error or timeout
  misaligned_out  out  1  one-cycle pulse, misaligned or illegal request

Function
REQ-003 SHALL implement FSM states IDLE, ADDR, DATA; all outputs registered.
REQ-004 IDLE, store_req_in=1, aligned: SHALL latch address, data, mask; next state ADDR.
REQ-005 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; store_size_in=11 any address.
REQ-006 IDLE, store_req_in=1, misaligned: SHALL pulse misaligned_out next cycle, stay IDLE, no bus activity.
REQ-007 Data: byte -> {4{rs2[7:0]}}; half -> {2{rs2[15:0]}}; word -> rs2.
REQ-008 Mask: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111.
REQ-009 ADDR: htrans=2'b10, dmwr_req=1, busy=1; address/data/mask held stable.
REQ-010 ADDR, ahb_ready_in=1: SHALL go to DATA; else SHALL stay ADDR.
REQ-011 DATA: htrans=2'b00, dmwr_req=0, busy=1, dmdata held stable.
REQ-012 DATA, ready=1, resp=0: SHALL pulse store_done_out next cycle, go IDLE.
REQ-013 DATA, ready=1, resp=1: SHALL pulse store_err_out next cycle, go IDLE; no done pulse.
REQ-014 8-bit wait counter SHALL clear on each state entry, increment on each ready=0 cycle in ADDR/DATA, clear on ready=1.
REQ-015 Counter reaching TIMEOUT_CYCLES SHALL pulse store_err_out, go IDLE; timeout takes priority over any same-cycle transition.
REQ-016 store_req_in SHALL be ignored while busy; no queuing.
REQ-017 Best-case latency: request accepted edge k, ready=1 at k+1 and k+2 -> store_done_out high in cycle after edge k+2.
REQ-018 In IDLE, dmaddr/dmdata/mask SHALL hold last latched values; dmwr_req=0, htrans=2'b00.
REQ-019 done, err and misaligned pulses SHALL be mutually exclusive.

Reset
REQ-020 When ms_riscv32_mp_rst_in=0 at a clock edge: state IDLE, counter 0, all outputs 0 (htrans 2'b00).
REQ-021 Reset asserted in ADDR or DATA SHALL abort the transfer with no done/err pulse; reset has priority over every event.

Verification
REQ-022 Word store: addr 0x1000_0004, rs2 0xDEADBEEF, ready=1 -> dmaddr 0x1000_0004, mask 4'b1111, data 0xDEADBEEF, done pulse 3 cycles after request.
REQ-023 Byte store: addr 0x2000_0003, rs2 0x0000_00A5 -> dmaddr 0x2000_0000, mask 4'b1000, data 0xA5A5A5A5; half at addr 0x...02, rs2 0x1234 -> mask 4'b1100, data 0x12341234.
REQ-024 Half at addr 0x...01, word at 0x...02, size 11 -> one misaligned_out pulse each, htrans stays 00, busy stays 0.
REQ-025 ready=0 for 3 cycles in ADDR, then ready=1, resp=1 in DATA -> address held 4 cycles, err pulse, no done.
REQ-026 ready held 0, TIMEOUT_CYCLES=15 -> err pulse after 15 wait cycles, IDLE; reset asserted mid-ADDR -> all outputs 0 next cycle, no pulses.

Source files
------------

// File: rtl/msrv32_store_unit.sv
// Store unit: turns a pipeline store request into one AHB-style write (address phase, then data phase).
// Aligned requests get lane-replicated data and byte strobes. Misaligned requests are rejected. Stalled transfers abort on timeout.
module msrv32_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        store_req_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  store_size_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        su_busy_out,
  output logic        store_done_out,
  output logic        store_err_out,
  output logic        misaligned_out
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic        wr_req_q, wr_req_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
  logic        req_misaligned;

  always_comb begin
    req_misaligned = 1'b0;
    case (store_size_in)
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = iadder_in[0];
      2'b10:   req_misaligned = (iadder_in[1:0] != 2'b00);
      default: req_misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (store_req_in) begin
          if (req_misaligned) begin
            mis_d = 1'b1;
          end else begin
            state_d = ADDR;
            cnt_d   = 8'd0;
            addr_d  = {iadder_in[31:2], 2'b00};
            case (store_size_in)
              2'b00: begin
                data_d = {4{rs2_in[7:0]}};
                mask_d = 4'b0001 << iadder_in[1:0];
              end
              2'b01: begin
                data_d = {2{rs2_in[15:0]}};
                mask_d = 4'b0011 << {iadder_in[1], 1'b0};
              end
              default: begin
                data_d = rs2_in;
                mask_d = 4'b1111;
              end
            endcase
          end
        end
      end

      ADDR, DATA: begin
        if (!ahb_ready_in) begin
          cnt_d = cnt_q + 8'd1;
          // Timeout check uses the incremented count so the abort lands on the Nth stalled edge.
          if (cnt_d == TIMEOUT_LIMIT) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = 8'd0;
          if (state_q == ADDR) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            err_d   = ahb_resp_in;
            done_d  = ~ahb_resp_in;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    wr_req_d = (state_d == ADDR);
    htrans_d = (state_d == ADDR) ? 2'b10 : 2'b00;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      mask_q   <= 4'd0;
      wr_req_q <= 1'b0;
      htrans_q <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      wr_req_q <= wr_req_d;
      htrans_q <= htrans_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
    end
  end

  assign ms_riscv32_mp_dmaddr_out    = addr_q;
  assign ms_riscv32_mp_dmdata_out    = data_q;
  assign ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign ms_riscv32_mp_dmwr_req_out  = wr_req_q;
  assign ahb_htrans_out              = htrans_q;
  assign su_busy_out                 = busy_q;
  assign store_done_out              = done_q;
  assign store_err_out               = err_q;
  assign misaligned_out              = mis_q;

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Bench for msrv32_store_unit: directed and random stores with scripted bus stalls.
// Expected outcomes are queued at issue time and consumed by a monitor on each completion pulse.
module tb_msrv32_store_unit;

  localparam int T = 15;
  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_MIS  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        store_req = 1'b0;
  logic [31:0] iadder = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [1:0]  size = 2'b00;
  logic        ready = 1'b0;
  logic        resp = 1'b0;
  logic [31:0] dmaddr, dmdata;
  logic [3:0]  mask;
  logic        wr_req, busy, done, err, mis;
  logic [1:0]  htrans;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_t;

  exp_t exp_q[$];

  msrv32_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .ms_riscv32_mp_clk_in       (clk),
    .ms_riscv32_mp_rst_in       (rst_n),
    .store_req_in               (store_req),
    .iadder_in                  (iadder),
    .rs2_in                     (rs2),
    .store_size_in              (size),
    .ahb_ready_in               (ready),
    .ahb_resp_in                (resp),
    .ms_riscv32_mp_dmaddr_out   (dmaddr),
    .ms_riscv32_mp_dmdata_out   (dmdata),
    .ms_riscv32_mp_dmwr_mask_out(mask),
    .ms_riscv32_mp_dmwr_req_out (wr_req),
    .ahb_htrans_out             (htrans),
    .su_busy_out                (busy),
    .store_done_out             (done),
    .store_err_out              (err),
    .misaligned_out             (mis)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: lanes written are [off, off+n); each lane carries rs2 byte (lane mod n).
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                 input int aw, input int dw, input logic rsp, input int k);
    exp_t e;
    int n, off;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    e.addr = {a[31:2], 2'b00};
    e.mask = 4'b0000;
    e.data = 32'd0;
    for (int b = 0; b < 4; b++) begin
      e.mask[b] = (b >= off) && (b < off + n);
      e.data[8*b +: 8] = d[8*(b % n) +: 8];
    end
    if (sz == 2'b11 || (off % n) != 0) begin
      e.kind = K_MIS;
      e.cyc  = k;
    end else if (aw >= T) begin
      e.kind = K_ERR;
      e.cyc  = k + T;
    end else if (dw >= T) begin
      e.kind = K_ERR;
      e.cyc  = k + aw + 1 + T;
    end else begin
      e.kind = rsp ? K_ERR : K_DONE;
      e.cyc  = k + aw + dw + 2;
    end
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (done || err || mis)) begin
        chk("pulse_onehot", 32'($countones({done, err, mis})), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, done, err, mis}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("kind", (done ? K_DONE : err ? K_ERR : K_MIS), e.kind);
          chk("pulse_cycle", cyc, e.cyc);
          if (e.kind != K_MIS) begin
            chk("held_addr", dmaddr, e.addr);
            chk("held_data", dmdata, e.data);
            chk("held_mask", {28'd0, mask}, {28'd0, e.mask});
          end
          chk("idle_htrans", {30'd0, htrans}, 32'd0);
          chk("idle_busy", {31'd0, busy}, 32'd0);
        end
      end
    end
  endtask

  // While the unit is busy, request inputs carry junk that must be ignored.
  task automatic drive(input logic rdy, input logic rsp);
    ready = rdy;
    resp = rsp;
    store_req = 1'($urandom);
    iadder = $urandom;
    rs2 = $urandom;
    size = 2'($urandom);
    @(negedge clk);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input int aw, input int dw, input logic rsp);
    exp_t e;
    e = model(a, d, sz, aw, dw, rsp, cyc + 1);
    exp_q.push_back(e);
    store_req = 1'b1;
    iadder = a;
    rs2 = d;
    size = sz;
    ready = 1'($urandom);
    resp = 1'($urandom);
    @(negedge clk);
    if (e.kind == K_MIS) begin
      chk("mis_htrans", {30'd0, htrans}, 32'd0);
      chk("mis_busy", {31'd0, busy}, 32'd0);
    end else begin
      chk("addr_htrans", {30'd0, htrans}, 32'h2);
      chk("addr_wrreq", {31'd0, wr_req}, 32'd1);
      chk("addr_busy", {31'd0, busy}, 32'd1);
      chk("addr_dmaddr", dmaddr, e.addr);
      chk("addr_dmdata", dmdata, e.data);
      chk("addr_mask", {28'd0, mask}, {28'd0, e.mask});
      for (int i = 0; i < aw && i < T; i++) begin
        drive(1'b0, 1'($urandom));
        if (i + 1 < T) begin
          chk("addr_hold_htrans", {30'd0, htrans}, 32'h2);
          chk("addr_hold_dmaddr", dmaddr, e.addr);
        end
      end
      if (aw < T) begin
        drive(1'b1, 1'($urandom));
        chk("data_htrans", {30'd0, htrans}, 32'd0);
        chk("data_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < dw && i < T; i++) begin
          drive(1'b0, 1'($urandom));
          if (i + 1 < T) chk("data_hold_dmdata", dmdata, e.data);
        end
        if (dw < T) drive(1'b1, rsp);
      end
    end
    store_req = 1'b0;
    ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dmaddr"}, dmaddr, 32'd0);
    chk({tag, "_dmdata"}, dmdata, 32'd0);
    chk({tag, "_ctl"}, {23'd0, mask, wr_req, htrans, busy, done, err, mis}, 32'd0);
  endtask

  task automatic reset_during(input bit in_data);
    store_req = 1'b1;
    iadder = 32'h3000_0008;
    rs2 = 32'hCAFE_F00D;
    size = 2'b10;
    ready = 1'b0;
    @(negedge clk);
    if (in_data) drive(1'b1, 1'b0);
    store_req = 1'b0;
    rst_n = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk_all_zero(in_data ? "rst_data" : "rst_addr");
    rst_n = 1'b1;
    ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_store(32'h1000_0004, 32'hDEAD_BEEF, 2'b10, 0, 0, 1'b0);
    do_store(32'h2000_0003, 32'h0000_00A5, 2'b00, 0, 0, 1'b0);
    do_store(32'h2000_0002, 32'h0000_1234, 2'b01, 0, 0, 1'b0);
    do_store(32'h2000_0001, 32'h0000_5678, 2'b01, 0, 0, 1'b0);
    do_store(32'h2000_0002, 32'h1111_2222, 2'b10, 0, 0, 1'b0);
    do_store(32'h2000_0000, 32'h3333_4444, 2'b11, 0, 0, 1'b0);
    do_store(32'h4000_0010, 32'h0BAD_F00D, 2'b10, 3, 0, 1'b1);
    do_store(32'h5000_0000, 32'h0102_0304, 2'b10, T, 0, 1'b0);
    do_store(32'h5000_0001, 32'h0506_0708, 2'b00, T - 1, 0, 1'b0);
    do_store(32'h5000_0002, 32'h090A_0B0C, 2'b01, 1, T, 1'b0);
    do_store(32'h5000_0004, 32'h0D0E_0F10, 2'b10, 0, T - 1, 1'b0);
    reset_during(1'b0);
    reset_during(1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          aw, dw;
      a  = $urandom;
      sz = 2'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'b10) ? 2'b00 : (sz == 2'b01) ? {a[1], 1'b0} : a[1:0];
      aw = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3);
      do_store(a, $urandom, sz, aw, dw, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
